// File: rtl/hazard_stall_controller.sv
// Hazard sequencer for the 5-stage core: load-use bubbles, branch flushes and
// front-end freeze while a multi-cycle MDU op occupies EX, with timeout abort.
module hazard_stall_controller #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_use_rs1,
    input  logic             IFID_use_rs2,
    input  logic [4:0]       IDEX_rd,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_is_mdu,
    input  logic             branch_taken,
    input  logic             mdu_done,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IDEX_write,
    output logic             IDEX_bubble,
    output logic             EXMEM_bubble,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             mdu_start,
    output logic             mdu_abort,
    output logic             mdu_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

    typedef enum logic {RUN, MDU_WAIT} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              start_nxt, abort_nxt, err_set;
    logic              load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign load_use = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                      ((IFID_use_rs1 && (IDEX_rd == IFID_rs1)) ||
                       (IFID_use_rs2 && (IDEX_rd == IFID_rs2)));

    always_comb begin
        PC_write     = 1'b1;
        IFID_write   = 1'b1;
        IDEX_write   = 1'b1;
        IDEX_bubble  = 1'b0;
        EXMEM_bubble = 1'b0;
        IFID_flush   = 1'b0;
        IDEX_flush   = 1'b0;
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        start_nxt    = 1'b0;
        abort_nxt    = 1'b0;
        err_set      = 1'b0;
        // Strobes are forced to their idle values for the whole reset interval.
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        IFID_flush = 1'b1;
                        IDEX_flush = 1'b1;
                    end else if (load_use) begin
                        PC_write    = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_bubble = 1'b1;
                    end else if (IDEX_is_mdu) begin
                        PC_write     = 1'b0;
                        IFID_write   = 1'b0;
                        IDEX_write   = 1'b0;
                        EXMEM_bubble = 1'b1;
                        start_nxt    = 1'b1;
                        wait_nxt     = '0;
                        state_nxt    = MDU_WAIT;
                    end
                end
                MDU_WAIT: begin
                    if (!mdu_done) begin
                        PC_write     = 1'b0;
                        IFID_write   = 1'b0;
                        IDEX_write   = 1'b0;
                        EXMEM_bubble = 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            abort_nxt = 1'b1;
                            err_set   = 1'b1;
                            state_nxt = RUN;
                        end else begin
                            wait_nxt = wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mdu_start    <= 1'b0;
            mdu_abort    <= 1'b0;
            mdu_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            mdu_start <= start_nxt;
            mdu_abort <= abort_nxt;
            mdu_err   <= mdu_err | err_set;
            if (!PC_write) stall_cycles <= sat_inc(stall_cycles);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: a short-timeout/narrow-counter
// instance (a_*) and a default-parameter instance (b_*) share one stimulus.
module tb_hazard_stall_controller;

    logic       clk, rst_n;
    logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
    logic       IFID_use_rs1, IFID_use_rs2, IDEX_MemRead, IDEX_is_mdu;
    logic       branch_taken, mdu_done;

    logic        a_PC_write, a_IFID_write, a_IDEX_write, a_IDEX_bubble, a_EXMEM_bubble;
    logic        a_IFID_flush, a_IDEX_flush, a_mdu_start, a_mdu_abort, a_mdu_err;
    logic [3:0]  a_stall;
    logic        b_PC_write, b_IFID_write, b_IDEX_write, b_IDEX_bubble, b_EXMEM_bubble;
    logic        b_IFID_flush, b_IDEX_flush, b_mdu_start, b_mdu_abort, b_mdu_err;
    logic [31:0] b_stall;

    int total = 0;
    int bad   = 0;

    hazard_stall_controller #(.MDU_TIMEOUT(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
        .IDEX_rd(IDEX_rd), .IDEX_MemRead(IDEX_MemRead), .IDEX_is_mdu(IDEX_is_mdu),
        .branch_taken(branch_taken), .mdu_done(mdu_done),
        .PC_write(a_PC_write), .IFID_write(a_IFID_write), .IDEX_write(a_IDEX_write),
        .IDEX_bubble(a_IDEX_bubble), .EXMEM_bubble(a_EXMEM_bubble),
        .IFID_flush(a_IFID_flush), .IDEX_flush(a_IDEX_flush),
        .mdu_start(a_mdu_start), .mdu_abort(a_mdu_abort), .mdu_err(a_mdu_err),
        .stall_cycles(a_stall)
    );

    hazard_stall_controller #(.MDU_TIMEOUT(64), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
        .IDEX_rd(IDEX_rd), .IDEX_MemRead(IDEX_MemRead), .IDEX_is_mdu(IDEX_is_mdu),
        .branch_taken(branch_taken), .mdu_done(mdu_done),
        .PC_write(b_PC_write), .IFID_write(b_IFID_write), .IDEX_write(b_IDEX_write),
        .IDEX_bubble(b_IDEX_bubble), .EXMEM_bubble(b_EXMEM_bubble),
        .IFID_flush(b_IFID_flush), .IDEX_flush(b_IDEX_flush),
        .mdu_start(b_mdu_start), .mdu_abort(b_mdu_abort), .mdu_err(b_mdu_err),
        .stall_cycles(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        IFID_rs1 = 5'd0; IFID_rs2 = 5'd0; IDEX_rd = 5'd0;
        IFID_use_rs1 = 1'b0; IFID_use_rs2 = 1'b0; IDEX_MemRead = 1'b0;
        IDEX_is_mdu = 1'b0; branch_taken = 1'b0; mdu_done = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        clear_in();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        // reset: strobes idle even with hazards on the inputs
        rst_n = 1'b0;
        clear_in();
        branch_taken = 1'b1; IDEX_MemRead = 1'b1; IDEX_rd = 5'd5;
        IFID_rs2 = 5'd5; IFID_use_rs2 = 1'b1; IDEX_is_mdu = 1'b1; mdu_done = 1'b1;
        #2;
        chk("rst_pc_write", a_PC_write, 1);
        chk("rst_ifid_write", a_IFID_write, 1);
        chk("rst_idex_write", a_IDEX_write, 1);
        chk("rst_ifid_flush", a_IFID_flush, 0);
        chk("rst_idex_bubble", a_IDEX_bubble, 0);
        chk("rst_exmem_bubble", a_EXMEM_bubble, 0);
        #6;
        chk("rst_mdu_start", a_mdu_start, 0);
        chk("rst_mdu_err", a_mdu_err, 0);
        chk("rst_stall", b_stall, 0);
        rst_n = 1'b1;
        clear_in();

        // load-use on rs2
        IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; IFID_rs2 = 5'd5; IFID_use_rs2 = 1'b1;
        #1;
        chk("lu_pc_write", a_PC_write, 0);
        chk("lu_ifid_write", a_IFID_write, 0);
        chk("lu_idex_write", a_IDEX_write, 1);
        chk("lu_idex_bubble", a_IDEX_bubble, 1);
        tick();
        IDEX_MemRead = 1'b0;
        #1;
        chk("lu_release_pc", a_PC_write, 1);
        chk("lu_release_bubble", a_IDEX_bubble, 0);
        chk("lu_stall_a", a_stall, 1);
        chk("lu_stall_b", b_stall, 1);
        // rd = x0 never stalls
        IDEX_MemRead = 1'b1; IDEX_rd = 5'd0; IFID_rs2 = 5'd0;
        #1;
        chk("lu_x0_pc", a_PC_write, 1);
        chk("lu_x0_bubble", a_IDEX_bubble, 0);
        tick();
        // rs1 match, then same match with use_rs1 low
        IDEX_rd = 5'd7; IFID_rs1 = 5'd7; IFID_use_rs1 = 1'b1; IFID_use_rs2 = 1'b0;
        #1;
        chk("lu_rs1_bubble", a_IDEX_bubble, 1);
        IFID_use_rs1 = 1'b0;
        #1;
        chk("lu_rs1_unused", a_IDEX_bubble, 0);
        tick();

        // branch beats load-use
        IDEX_rd = 5'd5; IFID_rs2 = 5'd5; IFID_use_rs2 = 1'b1; branch_taken = 1'b1;
        #1;
        chk("br_ifid_flush", a_IFID_flush, 1);
        chk("br_idex_flush", a_IDEX_flush, 1);
        chk("br_pc_write", a_PC_write, 1);
        chk("br_idex_bubble", a_IDEX_bubble, 0);
        tick();
        clear_in();
        #1;
        chk("br_stall", a_stall, 1);

        // MDU op completing after 10 frozen cycles (default instance)
        do_reset();
        IDEX_is_mdu = 1'b1;
        #1;
        chk("mdu_run_pc", b_PC_write, 0);
        chk("mdu_run_idex_write", b_IDEX_write, 0);
        chk("mdu_run_exmem", b_EXMEM_bubble, 1);
        chk("mdu_run_start", b_mdu_start, 0);
        tick();
        branch_taken = 1'b1; IDEX_MemRead = 1'b1; IDEX_rd = 5'd5;
        IFID_rs2 = 5'd5; IFID_use_rs2 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("mdu_wait_pc", b_PC_write, 0);
            chk("mdu_wait_exmem", b_EXMEM_bubble, 1);
            chk("mdu_wait_flush", b_IFID_flush, 0);
            chk("mdu_wait_bubble", b_IDEX_bubble, 0);
            chk("mdu_wait_start", b_mdu_start, 32'(i == 0));
            tick();
        end
        branch_taken = 1'b0; IDEX_MemRead = 1'b0; IFID_use_rs2 = 1'b0;
        mdu_done = 1'b1;
        #1;
        chk("mdu_done_pc", b_PC_write, 1);
        chk("mdu_done_ifid", b_IFID_write, 1);
        chk("mdu_done_idex", b_IDEX_write, 1);
        chk("mdu_done_exmem", b_EXMEM_bubble, 0);
        chk("mdu_done_stall", b_stall, 10);
        tick();
        mdu_done = 1'b0; IDEX_is_mdu = 1'b0;
        #1;
        chk("mdu_after_pc", b_PC_write, 1);
        chk("mdu_after_abort", b_mdu_abort, 0);
        chk("mdu_after_err", b_mdu_err, 0);
        chk("mdu_after_stall", b_stall, 10);
        mdu_done = 1'b1;
        #1;
        chk("done_in_run_pc", b_PC_write, 1);
        tick();
        mdu_done = 1'b0;
        #1;
        chk("done_in_run_stall", b_stall, 10);

        // timeout abort with MDU_TIMEOUT=8
        do_reset();
        IDEX_is_mdu = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("to_wait_pc", a_PC_write, 0);
            chk("to_wait_abort", a_mdu_abort, 0);
            tick();
        end
        IDEX_is_mdu = 1'b0;
        #1;
        chk("to_abort", a_mdu_abort, 1);
        chk("to_err", a_mdu_err, 1);
        chk("to_run_pc", a_PC_write, 1);
        chk("to_stall", a_stall, 9);
        tick();
        #1;
        chk("to_abort_pulse", a_mdu_abort, 0);
        chk("to_err_sticky", a_mdu_err, 1);
        // done on the last permitted wait cycle wins over the timeout
        IDEX_is_mdu = 1'b1;
        tick();
        repeat (7) tick();
        mdu_done = 1'b1;
        #1;
        chk("to_done_pc", a_PC_write, 1);
        chk("to_done_exmem", a_EXMEM_bubble, 0);
        tick();
        mdu_done = 1'b0; IDEX_is_mdu = 1'b0;
        #1;
        chk("to_done_abort", a_mdu_abort, 0);
        chk("to_done_err", a_mdu_err, 1);
        chk("to_done_stall_sat", a_stall, 15);

        // asynchronous reset in the middle of MDU_WAIT
        IDEX_is_mdu = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_pc", a_PC_write, 1);
        chk("mr_exmem", a_EXMEM_bubble, 0);
        chk("mr_err", a_mdu_err, 0);
        chk("mr_stall", a_stall, 0);
        chk("mr_start", a_mdu_start, 0);
        tick();
        chk("mr_abort", a_mdu_abort, 0);
        rst_n = 1'b1;
        #1;
        chk("mr_restart_exmem", a_EXMEM_bubble, 1);
        chk("mr_restart_pc", a_PC_write, 0);
        tick();
        chk("mr_restart_start", a_mdu_start, 1);
        chk("mr_restart_stall", a_stall, 1);
        mdu_done = 1'b1;
        #1;
        chk("mr_restart_done", a_PC_write, 1);
        tick();
        clear_in();

        // counter saturation with CNT_W=4
        do_reset();
        IDEX_MemRead = 1'b1; IDEX_rd = 5'd3; IFID_rs1 = 5'd3; IFID_use_rs1 = 1'b1;
        repeat (14) tick();
        chk("sat_14", a_stall, 14);
        tick();
        chk("sat_15", a_stall, 15);
        repeat (5) tick();
        chk("sat_hold", a_stall, 15);
        chk("sat_wide", b_stall, 20);
        clear_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
